// File: rtl/i2c_seq_pkg.sv
// Purpose: shared types and command-word layout for the I2C command sequencer.
// Latency: n/a (types, constants and a packing helper only).
// Backpressure: n/a.
package i2c_seq_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int CMD_W  = ADDR_W + 1 + DATA_W;

    // Command word layout, MSB to LSB: {addr, rw, wdata}
    localparam int WDATA_LSB = 0;
    localparam int RW_BIT    = DATA_W;
    localparam int ADDR_LSB  = DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } seq_state_t;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [ADDR_W-1:0] addr,
        input logic              rw,
        input logic [DATA_W-1:0] wdata
    );
        return {addr, rw, wdata};
    endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Purpose: synchronous command FIFO with full/empty/level, extra pointer bit for wrap.
// Latency: a word pushed at edge N is visible on pop_dat (empty=0) right after edge N.
// Backpressure: push ignored while full (full is registered-state only, no same-cycle bypass).
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CMD_W = 16
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   push,
    input  logic [CMD_W-1:0]       push_dat,
    input  logic                   pop,
    output logic [CMD_W-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [CMD_W-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("i2c_cmd_fifo: DEPTH must be a power of 2 and >= 2");
    end

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; wraps naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (!areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Purpose: queue I2C commands and run them one at a time on the master, one in-order response each.
// Latency: command pushed at edge N can raise m_enable after edge N+1; response after master busy falls.
// Backpressure: cmd_ready = !full; rsp held until rsp_ready, no launch while a response is pending.
// Optional: define I2C_SEQ_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES with rsp_err=1.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic                   cmd_rw,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ADDR_W-1:0]      rsp_addr,
    output logic                   rsp_rw,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_data_in,
    output logic                   m_rw,
    output logic                   m_enable,
    input  logic [DATA_W-1:0]      m_data_out,
    input  logic                   m_busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   seq_busy
);

    seq_state_t       state;
    logic [CMD_W-1:0] push_dat;
    logic [CMD_W-1:0] pop_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("i2c_cmd_sequencer: TIMEOUT_CYCLES must be >= 2");
    end

    assign push_dat  = pack_cmd(cmd_addr, cmd_rw, cmd_wdata);
    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !m_busy;
    assign seq_busy  = (state != ST_IDLE);

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_fifo (
        .clk      (clk),
        .areset   (areset),
        .push     (cmd_valid),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    // tmo_cnt holds (cycles spent in LAUNCH+BUSY) - 1; hit marks the last allowed cycle.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    // Transaction FSM; m_* hold the active command and retain it after completion.
    always_ff @(posedge clk) begin
        if (!areset) begin
            state     <= ST_IDLE;
            m_addr    <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
            m_enable  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rw    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        m_addr    <= pop_dat[ADDR_LSB +: ADDR_W];
                        m_rw      <= pop_dat[RW_BIT];
                        m_data_in <= pop_dat[WDATA_LSB +: DATA_W];
                        m_enable  <= 1'b1;
                        state     <= ST_LAUNCH;
`ifdef I2C_SEQ_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                ST_LAUNCH: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tmo_hit) begin
                        m_enable  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_addr  <= m_addr;
                        rsp_rw    <= m_rw;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end else
`endif
                    if (m_busy) begin
                        m_enable <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tmo_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_addr  <= m_addr;
                        rsp_rw    <= m_rw;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end else
`endif
                    if (!m_busy) begin
                        rsp_valid <= 1'b1;
                        rsp_addr  <= m_addr;
                        rsp_rw    <= m_rw;
                        rsp_rdata <= m_rw ? m_data_out : '0;
                        rsp_err   <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Purpose: scoreboard bench for i2c_cmd_sequencer against a small behavioural I2C master.
// Latency: master raises busy one cycle after enable, holds it LAT+1 cycles, then drives data_out.
// Backpressure: bench toggles rsp_ready and overfills the FIFO to exercise stalls.
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int LAT   = 5;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_rw, rsp_err;
    logic [6:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic       m_rw, m_enable, m_busy;
    logic [7:0] m_data_out = 8'h00;
    logic [2:0] fifo_level;
    logic       seq_busy;

    logic       force_busy = 1'b0;
    logic       mdl_busy = 1'b0;
    logic [2:0] bcnt = 3'd0;
    logic [6:0] mdl_addr = 7'd0;
    logic       mdl_rw = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;
    rsp_t sb_q[$];
    rsp_t exp_r;

    logic mon_on = 1'b0;
    logic prev_en = 1'b0;
    logic prev_busy = 1'b0;

    assign m_busy = force_busy | mdl_busy;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_rw     (cmd_rw),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_rw     (rsp_rw),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_rw       (m_rw),
        .m_enable   (m_enable),
        .m_data_out (m_data_out),
        .m_busy     (m_busy),
        .fifo_level (fifo_level),
        .seq_busy   (seq_busy)
    );

    function automatic logic [7:0] slave_rd(input logic [6:0] a);
        case (a)
            7'h57:   return 8'hCD;
            7'h58:   return 8'hF0;
            7'h59:   return 8'h3C;
            default: return 8'hEE;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] wd, input logic err);
        int w = 0;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 200) begin
            step();
            w++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 32'd0, 32'd1);
        else sb_q.push_back({a, rw, (err || !rw) ? 8'h00 : slave_rd(a), err});
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while ((sb_q.size() != 0 || seq_busy) && w < 500) begin
            step();
            w++;
        end
        check(tag, sb_q.size(), 0);
    endtask

    // Behavioural master: latch on enable while idle, stay busy, then present read data.
    always @(posedge clk) begin
        if (!m_busy && m_enable) begin
            mdl_busy <= 1'b1;
            bcnt     <= 3'(LAT);
            mdl_addr <= m_addr;
            mdl_rw   <= m_rw;
        end else if (mdl_busy) begin
            if (bcnt == 3'd0) begin
                mdl_busy   <= 1'b0;
                m_data_out <= mdl_rw ? slave_rd(mdl_addr) : 8'h00;
            end else begin
                bcnt <= bcnt - 3'd1;
            end
        end
    end

    // Enable must stay up until the cycle after busy is seen, then drop.
    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_en && prev_busy) check("en_drop", m_enable, 0);
            else if (prev_en)         check("en_hold", m_enable, 1);
        end
        prev_en   = m_enable;
        prev_busy = m_busy;
    end

    // Scoreboard: each accepted response is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (areset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_r = sb_q.pop_front();
                check("rsp_addr",  rsp_addr,  exp_r.addr);
                check("rsp_rw",    rsp_rw,    exp_r.rw);
                check("rsp_rdata", rsp_rdata, exp_r.rdata);
                check("rsp_err",   rsp_err,   exp_r.err);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_rw    = 1'b0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        areset    = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_m_enable",  m_enable,  0);
        check("rst_level",     fifo_level, 0);
        check("rst_seq_busy",  seq_busy,  0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_m_addr",    m_addr,    0);
        areset = 1'b1;
        mon_on = 1'b1;
        step();

        // Single read with launch timing
        rsp_ready = 1'b1;
        send(7'h57, 1'b1, 8'h00, 1'b0);
        check("t1_no_early_launch", m_enable, 0);
        step();
        check("t1_launch",   m_enable, 1);
        check("t1_m_addr",   m_addr, 7'h57);
        check("t1_m_rw",     m_rw, 1);
        check("t1_seq_busy", seq_busy, 1);
        drain("t1_drain");

        // Back-to-back reads, in-order responses
        send(7'h58, 1'b1, 8'h00, 1'b0);
        send(7'h59, 1'b1, 8'h00, 1'b0);
        send(7'h57, 1'b1, 8'h00, 1'b0);
        check("t2_level", fifo_level, 2);
        drain("t2_drain");

        // Overfill with response stalled
        rsp_ready = 1'b0;
        send(7'h57, 1'b1, 8'h00, 1'b0);
        send(7'h58, 1'b1, 8'h00, 1'b0);
        send(7'h59, 1'b1, 8'h00, 1'b0);
        send(7'h59, 1'b0, 8'h11, 1'b0);
        send(7'h58, 1'b1, 8'h00, 1'b0);
        check("t3_level_full", fifo_level, DEPTH);
        check("t3_cmd_ready",  cmd_ready, 0);
        cmd_addr  = 7'h11;
        cmd_rw    = 1'b1;
        cmd_valid = 1'b1;
        repeat (30) step();
        check("t3_level_hold", fifo_level, DEPTH);
        check("t3_rsp_pending", rsp_valid, 1);
        check("t3_no_launch",  m_enable, 0);
        check("t3_ready_low",  cmd_ready, 0);
        cmd_valid = 1'b0;
        step();
        rsp_ready = 1'b1;
        drain("t3_drain");

        // Write transaction
        send(7'h58, 1'b0, 8'hA5, 1'b0);
        step();
        check("t4_m_data_in", m_data_in, 8'hA5);
        check("t4_m_rw",      m_rw, 0);
        drain("t4_drain");

`ifdef I2C_SEQ_TIMEOUT_EN
        // Timeout with master stuck busy; next command waits for busy to clear
        send(7'h57, 1'b1, 8'h00, 1'b1);
        send(7'h59, 1'b1, 8'h00, 1'b0);
        w = 0;
        while (!m_enable && w < 50) begin
            step();
            w++;
        end
        check("t5_launch_seen", m_enable, 1);
        force_busy = 1'b1;
        w = 0;
        while (!rsp_valid && w < 200) begin
            step();
            w++;
        end
        check("t5_tmo_cycles", w, TMO);
        check("t5_level", fifo_level, 1);
        repeat (10) step();
        check("t5_no_launch", m_enable, 0);
        check("t5_level_hold", fifo_level, 1);
        force_busy = 1'b0;
        drain("t5_drain");
`endif

        // Reset during BUSY with two commands queued
        send(7'h57, 1'b1, 8'h00, 1'b0);
        send(7'h58, 1'b1, 8'h00, 1'b0);
        send(7'h59, 1'b1, 8'h00, 1'b0);
        w = 0;
        while (!(m_busy && seq_busy && !m_enable) && w < 50) begin
            step();
            w++;
        end
        check("t6_in_busy", fifo_level, 2);
        mon_on = 1'b0;
        areset = 1'b0;
        step();
        check("t6_m_enable",  m_enable, 0);
        check("t6_level",     fifo_level, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_seq_busy",  seq_busy, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        sb_q.delete();
        areset = 1'b1;
        mon_on = 1'b1;
        repeat (20) step();
        check("t6_no_rsp", rsp_valid, 0);
        send(7'h59, 1'b1, 8'h00, 1'b0);
        drain("t6_recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
